// File: rtl/id_ex_ctrl_stage.sv
// ID/EX decode stage for RV32I: decodes instr into the EX/MEM/WB control bundle and registers it.
// Optional RV32M decode with multi-cycle busy counter is enabled by defining RV32M_EN.
module id_ex_ctrl_stage #(
  parameter int PC_W       = 32,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [PC_W-1:0] pc_in,
  input  logic            stall_in,
  input  logic            flush,
  output logic            ex_valid,
  output logic [PC_W-1:0] ex_pc,
  output logic            ex_alu_src,
  output logic            ex_mem_write,
  output logic            ex_mem_read,
  output logic            ex_wb_reg_file,
  output logic            ex_memtoreg,
  output logic            ex_branch,
  output logic            ex_jal,
  output logic            ex_jalr,
  output logic [2:0]      ex_mem_load_type,
  output logic [1:0]      ex_mem_store_type,
  output logic [3:0]      ex_alu_ctrl,
  output logic [2:0]      ex_branch_func3,
  output logic            ex_illegal,
  output logic            busy
);

  // Handshake: an instruction moves from ID into ID/EX on a clock where in_valid && in_ready;
  // in_ready drops while a multi-cycle op occupies EX, downstream stalls, or reset is asserted.

  typedef struct packed {
    logic       alu_src;
    logic       mem_write;
    logic       mem_read;
    logic       wb_reg_file;
    logic       memtoreg;
    logic       branch;
    logic       jal;
    logic       jalr;
    logic [2:0] load_type;
    logic [1:0] store_type;
    logic [3:0] alu_ctrl;
    logic [2:0] branch_func3;
  } ctrl_t;

  localparam ctrl_t CTRL_DEFAULT = '{
    alu_src: 1'b0, mem_write: 1'b0, mem_read: 1'b0, wb_reg_file: 1'b0,
    memtoreg: 1'b0, branch: 1'b0, jal: 1'b0, jalr: 1'b0,
    load_type: 3'b010, store_type: 2'b10, alu_ctrl: 4'b0000, branch_func3: 3'b000
  };

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [6:0] opcode;
  logic [2:0] func3;
  logic [6:0] func7;
  assign opcode = instr[6:0];
  assign func3  = instr[14:12];
  assign func7  = instr[31:25];

  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

  ctrl_t dec;
  logic  dec_illegal;
  logic  dec_is_m;

  always_comb begin
    dec         = CTRL_DEFAULT;
    dec_illegal = 1'b0;
    dec_is_m    = 1'b0;
    case (opcode)
      7'b0110011: begin
        dec.wb_reg_file = 1'b1;
        if (func7 == 7'b0000000 || func7 == 7'b0100000) begin
          case (func3)
            3'b000:  dec.alu_ctrl = func7[5] ? 4'b0001 : 4'b0000;
            3'b001:  dec.alu_ctrl = 4'b0101;
            3'b010:  dec.alu_ctrl = 4'b1000;
            3'b011:  dec.alu_ctrl = 4'b1001;
            3'b100:  dec.alu_ctrl = 4'b0100;
            3'b101:  dec.alu_ctrl = func7[5] ? 4'b0111 : 4'b0110;
            3'b110:  dec.alu_ctrl = 4'b0011;
            default: dec.alu_ctrl = 4'b0010;
          endcase
          if (func7[5] && func3 != 3'b000 && func3 != 3'b101) dec_illegal = 1'b1;
`ifdef RV32M_EN
        end else if (func7 == 7'b0000001) begin
          dec_is_m = 1'b1;
          case (func3)
            3'b000:                dec.alu_ctrl = 4'b1100;
            3'b001, 3'b010, 3'b011: dec.alu_ctrl = 4'b1101;
            3'b100, 3'b101:        dec.alu_ctrl = 4'b1110;
            default:               dec.alu_ctrl = 4'b1111;
          endcase
`endif
        end else begin
          dec_illegal = 1'b1;
        end
      end
      7'b0010011: begin
        dec.alu_src     = 1'b1;
        dec.wb_reg_file = 1'b1;
        case (func3)
          3'b000:  dec.alu_ctrl = 4'b0000;
          3'b001:  dec.alu_ctrl = 4'b0101;
          3'b010:  dec.alu_ctrl = 4'b1000;
          3'b011:  dec.alu_ctrl = 4'b1001;
          3'b100:  dec.alu_ctrl = 4'b0100;
          3'b101:  dec.alu_ctrl = (func7 == 7'b0100000) ? 4'b0111 : 4'b0110;
          3'b110:  dec.alu_ctrl = 4'b0011;
          default: dec.alu_ctrl = 4'b0010;
        endcase
        if (func3 == 3'b001 && func7 != 7'b0000000) dec_illegal = 1'b1;
        if (func3 == 3'b101 && func7 != 7'b0000000 && func7 != 7'b0100000) dec_illegal = 1'b1;
      end
      7'b0000011: begin
        dec.alu_src     = 1'b1;
        dec.wb_reg_file = 1'b1;
        dec.mem_read    = 1'b1;
        dec.memtoreg    = 1'b1;
        case (func3)
          3'b000:  dec.load_type = 3'b000;
          3'b001:  dec.load_type = 3'b001;
          3'b010:  dec.load_type = 3'b010;
          3'b100:  dec.load_type = 3'b011;
          3'b101:  dec.load_type = 3'b100;
          default: dec_illegal   = 1'b1;
        endcase
      end
      7'b0100011: begin
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
        case (func3)
          3'b000:  dec.store_type = 2'b00;
          3'b001:  dec.store_type = 2'b01;
          3'b010:  dec.store_type = 2'b10;
          default: dec_illegal    = 1'b1;
        endcase
      end
      7'b1100011: begin
        dec.branch       = 1'b1;
        dec.alu_ctrl     = 4'b0001;
        dec.branch_func3 = func3;
        if (func3 == 3'b010 || func3 == 3'b011) dec_illegal = 1'b1;
      end
      7'b1101111: begin
        dec.jal         = 1'b1;
        dec.wb_reg_file = 1'b1;
      end
      7'b1100111: begin
        dec.jalr        = 1'b1;
        dec.alu_src     = 1'b1;
        dec.wb_reg_file = 1'b1;
        if (func3 != 3'b000) dec_illegal = 1'b1;
      end
      7'b0110111: begin
        dec.wb_reg_file = 1'b1;
        dec.alu_ctrl    = 4'b1010;
      end
      7'b0010111: begin
        dec.wb_reg_file = 1'b1;
        dec.alu_ctrl    = 4'b1011;
      end
      default: dec_illegal = 1'b1;
    endcase
    if (instr[1:0] != 2'b11) dec_illegal = 1'b1;
    // Illegal instructions travel as a live slot with no side-effect controls.
    if (dec_illegal) begin
      dec      = CTRL_DEFAULT;
      dec_is_m = 1'b0;
    end
  end

  assign in_ready = !busy && !stall_in && !rst;

  logic            accept;
  assign accept = in_valid && in_ready && !flush;

`ifdef RV32M_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else if (accept && dec_is_m) begin
      cnt_d = (func3[2] == 1'b0) ? CNT_W'(MUL_CYCLES - 1) : CNT_W'(DIV_CYCLES - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign busy = (cnt_q != '0);
`else
  logic [CNT_W-1:0] unused_cnt;
  logic             unused_is_m;
  assign unused_cnt  = '0;
  assign unused_is_m = dec_is_m;
  assign busy        = 1'b0;
`endif

  logic            valid_q, valid_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            illegal_q, illegal_d;
  ctrl_t           ctrl_q, ctrl_d;

  always_comb begin
    valid_d   = valid_q;
    pc_d      = pc_q;
    illegal_d = illegal_q;
    ctrl_d    = ctrl_q;
    if (flush) begin
      valid_d   = 1'b0;
      illegal_d = 1'b0;
      ctrl_d    = CTRL_DEFAULT;
    end else if (busy || stall_in) begin
      // hold
    end else if (in_valid) begin
      valid_d   = 1'b1;
      pc_d      = pc_in;
      illegal_d = dec_illegal;
      ctrl_d    = dec;
    end else begin
      valid_d   = 1'b0;
      illegal_d = 1'b0;
      ctrl_d    = CTRL_DEFAULT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      illegal_q <= 1'b0;
      ctrl_q    <= CTRL_DEFAULT;
    end else begin
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      illegal_q <= illegal_d;
      ctrl_q    <= ctrl_d;
    end
  end

  assign ex_valid          = valid_q;
  assign ex_pc             = pc_q;
  assign ex_illegal        = illegal_q;
  assign ex_alu_src        = ctrl_q.alu_src;
  assign ex_mem_write      = ctrl_q.mem_write;
  assign ex_mem_read       = ctrl_q.mem_read;
  assign ex_wb_reg_file    = ctrl_q.wb_reg_file;
  assign ex_memtoreg       = ctrl_q.memtoreg;
  assign ex_branch         = ctrl_q.branch;
  assign ex_jal            = ctrl_q.jal;
  assign ex_jalr           = ctrl_q.jalr;
  assign ex_mem_load_type  = ctrl_q.load_type;
  assign ex_mem_store_type = ctrl_q.store_type;
  assign ex_alu_ctrl       = ctrl_q.alu_ctrl;
  assign ex_branch_func3   = ctrl_q.branch_func3;

endmodule

// File: tb/tb_id_ex_ctrl_stage.sv
// Directed testbench for id_ex_ctrl_stage; RV32M_EN selects the multi-cycle expectations.
module tb_id_ex_ctrl_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, stall_in, flush;
  logic [31:0] instr, pc_in, ex_pc;
  logic        ex_valid, ex_alu_src, ex_mem_write, ex_mem_read, ex_wb_reg_file, ex_memtoreg;
  logic        ex_branch, ex_jal, ex_jalr, ex_illegal, busy;
  logic [2:0]  ex_mem_load_type, ex_branch_func3;
  logic [1:0]  ex_mem_store_type;
  logic [3:0]  ex_alu_ctrl;

  int n_checks = 0;
  int n_fail   = 0;

  id_ex_ctrl_stage #(.PC_W(32), .MUL_CYCLES(2), .DIV_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .pc_in(pc_in), .stall_in(stall_in), .flush(flush), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_alu_src(ex_alu_src), .ex_mem_write(ex_mem_write), .ex_mem_read(ex_mem_read),
    .ex_wb_reg_file(ex_wb_reg_file), .ex_memtoreg(ex_memtoreg), .ex_branch(ex_branch),
    .ex_jal(ex_jal), .ex_jalr(ex_jalr), .ex_mem_load_type(ex_mem_load_type),
    .ex_mem_store_type(ex_mem_store_type), .ex_alu_ctrl(ex_alu_ctrl),
    .ex_branch_func3(ex_branch_func3), .ex_illegal(ex_illegal), .busy(busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] i, input logic [31:0] pc);
    in_valid = 1'b1;
    instr    = i;
    pc_in    = pc;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall_in = 1'b0; flush = 1'b0;
    offer(32'h002081B3, 32'h0000_0040);
    step(); step();
    n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", ex_valid); end
    n_checks++; if (ex_pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h want 0", ex_pc); end
    n_checks++; if (ex_illegal !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_ill_busy: got %b%b want 00", ex_illegal, busy); end
    n_checks++; if (ex_mem_load_type !== 3'b010 || ex_mem_store_type !== 2'b10) begin n_fail++; $display("FAIL rst_types: got %b/%b want 010/10", ex_mem_load_type, ex_mem_store_type); end
    n_checks++; if ({ex_alu_src, ex_mem_write, ex_mem_read, ex_wb_reg_file, ex_memtoreg, ex_branch, ex_jal, ex_jalr} !== 8'h00) begin n_fail++; $display("FAIL rst_ctrls: nonzero controls"); end
    n_checks++; if (ex_alu_ctrl !== 4'b0000 || ex_branch_func3 !== 3'b000) begin n_fail++; $display("FAIL rst_alu: got %b/%b want 0000/000", ex_alu_ctrl, ex_branch_func3); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", in_ready); end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_add();
    offer(32'h002081B3, 32'h0000_0100);
    step();
    n_checks++; if (ex_valid !== 1'b1 || ex_illegal !== 1'b0) begin n_fail++; $display("FAIL add_valid: got v=%b ill=%b want 1 0", ex_valid, ex_illegal); end
    n_checks++; if (ex_alu_ctrl !== 4'b0000 || ex_wb_reg_file !== 1'b1 || ex_alu_src !== 1'b0) begin n_fail++; $display("FAIL add_ctrl: got alu=%b wb=%b src=%b want 0000 1 0", ex_alu_ctrl, ex_wb_reg_file, ex_alu_src); end
    n_checks++; if (ex_pc !== 32'h0000_0100) begin n_fail++; $display("FAIL add_pc: got %h want 100", ex_pc); end
  endtask

  task automatic test_load_bubble();
    offer(32'h0040A283, 32'h0000_0104);
    step();
    in_valid = 1'b0;
    n_checks++; if (ex_mem_read !== 1'b1 || ex_memtoreg !== 1'b1 || ex_mem_load_type !== 3'b010) begin n_fail++; $display("FAIL lw_ctrl: got rd=%b m2r=%b lt=%b want 1 1 010", ex_mem_read, ex_memtoreg, ex_mem_load_type); end
    n_checks++; if (ex_alu_src !== 1'b1 || ex_wb_reg_file !== 1'b1 || ex_mem_write !== 1'b0) begin n_fail++; $display("FAIL lw_src_wb: got src=%b wb=%b wr=%b want 1 1 0", ex_alu_src, ex_wb_reg_file, ex_mem_write); end
    step();
    n_checks++; if (ex_valid !== 1'b0 || ex_mem_read !== 1'b0 || ex_memtoreg !== 1'b0 || ex_wb_reg_file !== 1'b0) begin n_fail++; $display("FAIL bubble: got v=%b rd=%b m2r=%b wb=%b want 0 0 0 0", ex_valid, ex_mem_read, ex_memtoreg, ex_wb_reg_file); end
    n_checks++; if (ex_alu_src !== 1'b0 || ex_mem_load_type !== 3'b010) begin n_fail++; $display("FAIL bubble_default: got src=%b lt=%b want 0 010", ex_alu_src, ex_mem_load_type); end
  endtask

  task automatic test_mem_types();
    offer(32'h0040C283, 32'h0000_0200);  // LBU
    step();
    n_checks++; if (ex_mem_load_type !== 3'b011) begin n_fail++; $display("FAIL lbu_type: got %b want 011", ex_mem_load_type); end
    offer(32'h0040D283, 32'h0000_0204);  // LHU
    step();
    n_checks++; if (ex_mem_load_type !== 3'b100) begin n_fail++; $display("FAIL lhu_type: got %b want 100", ex_mem_load_type); end
    offer(32'h00110023, 32'h0000_0208);  // SB
    step();
    n_checks++; if (ex_mem_store_type !== 2'b00 || ex_mem_write !== 1'b1 || ex_wb_reg_file !== 1'b0 || ex_alu_src !== 1'b1) begin n_fail++; $display("FAIL sb_ctrl: got st=%b wr=%b wb=%b src=%b want 00 1 0 1", ex_mem_store_type, ex_mem_write, ex_wb_reg_file, ex_alu_src); end
    offer(32'h00112023, 32'h0000_020C);  // SW
    step();
    n_checks++; if (ex_mem_store_type !== 2'b10 || ex_mem_read !== 1'b0) begin n_fail++; $display("FAIL sw_ctrl: got st=%b rd=%b want 10 0", ex_mem_store_type, ex_mem_read); end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_stall();
    offer(32'h002081B3, 32'h0000_0300);  // ADD
    step();
    stall_in = 1'b1;
    offer(32'h402081B3, 32'h0000_0304);  // SUB
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready: got %b want 0", in_ready); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (ex_pc !== 32'h0000_0300 || ex_alu_ctrl !== 4'b0000 || ex_valid !== 1'b1) begin n_fail++; $display("FAIL stall_hold%0d: got pc=%h alu=%b v=%b want 300 0000 1", i, ex_pc, ex_alu_ctrl, ex_valid); end
    end
    stall_in = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL unstall_ready: got %b want 1", in_ready); end
    step();
    n_checks++; if (ex_pc !== 32'h0000_0304 || ex_alu_ctrl !== 4'b0001) begin n_fail++; $display("FAIL unstall_capture: got pc=%h alu=%b want 304 0001", ex_pc, ex_alu_ctrl); end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_flush();
    offer(32'h00209063, 32'h0000_0400);  // BNE
    step();
    n_checks++; if (ex_branch !== 1'b1 || ex_alu_ctrl !== 4'b0001 || ex_branch_func3 !== 3'b001 || ex_wb_reg_file !== 1'b0) begin n_fail++; $display("FAIL bne_ctrl: got br=%b alu=%b f3=%b wb=%b want 1 0001 001 0", ex_branch, ex_alu_ctrl, ex_branch_func3, ex_wb_reg_file); end
    flush = 1'b1; stall_in = 1'b1;
    offer(32'h002081B3, 32'h0000_0404);
    step();
    n_checks++; if (ex_valid !== 1'b0 || ex_branch !== 1'b0 || ex_branch_func3 !== 3'b000 || ex_alu_ctrl !== 4'b0000) begin n_fail++; $display("FAIL flush: got v=%b br=%b f3=%b alu=%b want 0 0 000 0000", ex_valid, ex_branch, ex_branch_func3, ex_alu_ctrl); end
    flush = 1'b0; stall_in = 1'b0; in_valid = 1'b0;
    step();
  endtask

  task automatic test_illegal();
    offer(32'h0000307F, 32'h0000_0500);
    step();
    n_checks++; if (ex_valid !== 1'b1 || ex_illegal !== 1'b1 || ex_pc !== 32'h0000_0500) begin n_fail++; $display("FAIL bad_opcode: got v=%b ill=%b pc=%h want 1 1 500", ex_valid, ex_illegal, ex_pc); end
    offer(32'h0000B003, 32'h0000_0504);
    step();
    n_checks++; if (ex_illegal !== 1'b1 || ex_mem_read !== 1'b0 || ex_wb_reg_file !== 1'b0 || ex_valid !== 1'b1) begin n_fail++; $display("FAIL bad_load: got ill=%b rd=%b wb=%b v=%b want 1 0 0 1", ex_illegal, ex_mem_read, ex_wb_reg_file, ex_valid); end
    offer(32'h00001067, 32'h0000_0508);  // JALR func3=001
    step();
    n_checks++; if (ex_illegal !== 1'b1 || ex_jalr !== 1'b0) begin n_fail++; $display("FAIL bad_jalr: got ill=%b jalr=%b want 1 0", ex_illegal, ex_jalr); end
    offer(32'h002081B0, 32'h0000_050C);  // low bits 00
    step();
    n_checks++; if (ex_illegal !== 1'b1 || ex_wb_reg_file !== 1'b0) begin n_fail++; $display("FAIL bad_lowbits: got ill=%b wb=%b want 1 0", ex_illegal, ex_wb_reg_file); end
    offer(32'h4010D093, 32'h0000_0510);  // SRAI
    step();
    n_checks++; if (ex_illegal !== 1'b0 || ex_alu_ctrl !== 4'b0111 || ex_alu_src !== 1'b1) begin n_fail++; $display("FAIL srai: got ill=%b alu=%b src=%b want 0 0111 1", ex_illegal, ex_alu_ctrl, ex_alu_src); end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_lui_jal();
    offer(32'h000010B7, 32'h0000_0600);  // LUI
    step();
    n_checks++; if (ex_alu_ctrl !== 4'b1010 || ex_wb_reg_file !== 1'b1 || ex_alu_src !== 1'b0) begin n_fail++; $display("FAIL lui: got alu=%b wb=%b src=%b want 1010 1 0", ex_alu_ctrl, ex_wb_reg_file, ex_alu_src); end
    offer(32'h0000006F, 32'h0000_0604);  // JAL
    step();
    n_checks++; if (ex_jal !== 1'b1 || ex_wb_reg_file !== 1'b1 || ex_alu_ctrl !== 4'b0000 || ex_jalr !== 1'b0) begin n_fail++; $display("FAIL jal: got jal=%b wb=%b alu=%b jalr=%b want 1 1 0000 0", ex_jal, ex_wb_reg_file, ex_alu_ctrl, ex_jalr); end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins [3] = '{32'h002081B3, 32'h402081B3, 32'h0020C1B3};
    logic [3:0]  alu [3] = '{4'b0000, 4'b0001, 4'b0100};
    for (int i = 0; i < 3; i++) begin
      offer(ins[i], 32'h0000_0700 + 32'(4 * i));
      step();
      n_checks++; if (ex_alu_ctrl !== alu[i] || ex_pc !== 32'h0000_0700 + 32'(4 * i) || ex_valid !== 1'b1) begin n_fail++; $display("FAIL b2b%0d: got alu=%b pc=%h v=%b want %b %h 1", i, ex_alu_ctrl, ex_pc, ex_valid, alu[i], 32'h0000_0700 + 32'(4 * i)); end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_muldiv();
    int busy_cycles;
    offer(32'h0220C1B3, 32'h0000_0800);  // DIV
    step();
`ifdef RV32M_EN
    offer(32'h002081B3, 32'h0000_0804);
    n_checks++; if (ex_valid !== 1'b1 || ex_alu_ctrl !== 4'b1110 || ex_illegal !== 1'b0) begin n_fail++; $display("FAIL div_ctrl: got v=%b alu=%b ill=%b want 1 1110 0", ex_valid, ex_alu_ctrl, ex_illegal); end
    busy_cycles = 0;
    while (busy === 1'b1 && busy_cycles < 20) begin
      busy_cycles++;
      n_checks++; if (in_ready !== 1'b0 || ex_alu_ctrl !== 4'b1110) begin n_fail++; $display("FAIL div_hold: got rdy=%b alu=%b want 0 1110", in_ready, ex_alu_ctrl); end
      step();
    end
    n_checks++; if (busy_cycles != 7) begin n_fail++; $display("FAIL div_busy_len: got %0d want 7", busy_cycles); end
    step();
    n_checks++; if (ex_pc !== 32'h0000_0804 || ex_alu_ctrl !== 4'b0000) begin n_fail++; $display("FAIL after_div: got pc=%h alu=%b want 804 0000", ex_pc, ex_alu_ctrl); end
    offer(32'h0220C1B3, 32'h0000_0808);
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++; if (busy !== 1'b0 || ex_valid !== 1'b0) begin n_fail++; $display("FAIL div_reset: got busy=%b v=%b want 0 0", busy, ex_valid); end
    offer(32'h0220C1B3, 32'h0000_080C);
    step();
    in_valid = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    n_checks++; if (busy !== 1'b0 || ex_valid !== 1'b0) begin n_fail++; $display("FAIL div_flush: got busy=%b v=%b want 0 0", busy, ex_valid); end
`else
    in_valid = 1'b0;
    n_checks++; if (ex_illegal !== 1'b1 || ex_valid !== 1'b1 || ex_wb_reg_file !== 1'b0) begin n_fail++; $display("FAIL div_illegal: got ill=%b v=%b wb=%b want 1 1 0", ex_illegal, ex_valid, ex_wb_reg_file); end
    busy_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      if (busy !== 1'b0) busy_cycles++;
      step();
    end
    n_checks++; if (busy_cycles != 0) begin n_fail++; $display("FAIL div_busy: got %0d busy cycles want 0", busy_cycles); end
`endif
    in_valid = 1'b0;
    step();
  endtask

  initial begin
    in_valid = 1'b0; instr = '0; pc_in = '0; stall_in = 1'b0; flush = 1'b0; rst = 1'b1;
    test_reset();
    test_add();
    test_load_bubble();
    test_mem_types();
    test_stall();
    test_flush();
    test_illegal();
    test_lui_jal();
    test_back_to_back();
    test_muldiv();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded 100000 time units");
    $fatal(1);
  end

endmodule
